regfile_sb: RTL and testbench

- Parametrised successor to the core's single-write register file.
- N read ports, one writeback port, register 0 hard-wired to zero.
- Per-register busy scoreboard so the non-forwarding pipeline can detect RAW hazards without comparing stage addresses itself.
- Soft-clear sequencer that zeroes the array one entry per cycle without a reset.
- Sits in ID (reads, issue) and WB (write).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Build option REGFILE_BYPASS_EN enables write-through bypass on reads.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, plus sticky
// double-issue error. Used by regfile_sb (REGFILE_BYPASS_EN agnostic).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     flush_en,
  input  logic [ADDR_W-1:0]        flush_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        busy,
  output logic                     err
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             dbl_issue;

  // Later assignments win: a new producer overrides its own writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr)
      busy_d[clr_addr] = 1'b0;
    if (set)
      busy_d[set_addr] = 1'b1;
    if (flush_en)
      busy_d[flush_addr] = 1'b0;
  end

  assign dbl_issue = set && busy_q[set_addr]
                  && !(clr && (clr_addr == set_addr));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      err    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (dbl_issue)
        err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_look
    logic [ADDR_W-1:0] a;
    assign a       = look_addr[k*ADDR_W +: ADDR_W];
    assign busy[k] = busy_q[a] && (a != '0);
  end
endmodule

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with busy scoreboard and soft clear.
// Define REGFILE_BYPASS_EN for write-through reads and busy masking.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_wren_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        rd_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rs_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     clr_req_i,
  output logic                     ready_o,
  output logic                     err_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic              flush_en;
  logic              wr_en;
  logic              iss_en;
  logic [NUM_RD-1:0] sb_busy;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign wr_en  = rd_wren_i && (rd_addr_i != '0)
               && (state_q == IDLE);
  assign iss_en = iss_valid_i && (iss_addr_i != '0) && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && clr_req_i)
        cnt_q <= ADDR_W'(1);
      else if (state_q == CLEAR && cnt_q != LAST)
        cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clr_req_i) state_d = CLEAR;
      CLEAR: if (cnt_q == LAST) state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = 1'b0;
    flush_en = 1'b0;
    unique case (state_q)
      IDLE:  ready_o  = 1'b1;
      CLEAR: flush_en = 1'b1;
    endcase
  end

  // Entry 0 is never written, so it stays zero from reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[rd_addr_i] <= rd_data_i;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set        (iss_en),
    .set_addr   (iss_addr_i),
    .clr        (wr_en),
    .clr_addr   (rd_addr_i),
    .flush_en   (flush_en),
    .flush_addr (cnt_q),
    .look_addr  (rs_addr_i),
    .busy       (sb_busy),
    .err        (err_o)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a = rs_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign hit = wr_en && (rd_addr_i == a);
`else
    assign hit = 1'b0;
`endif
    assign rs_data_o[k*DATA_W +: DATA_W] =
      (a == '0) ? '0 : (hit ? rd_data_i : mem_q[a]);
    assign rs_busy_o[k] = sb_busy[k] && !hit;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-queue bench for regfile_sb (NUM_RD=4); expectations
// follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wren;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rs_data;
  logic [NR-1:0] rs_busy;
  logic          iss;
  logic [AW-1:0] iss_addr;
  logic          clr_req;
  logic          ready;
  logic          err;
  int            clr_len;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_wren_i   (wren),
    .rd_addr_i   (waddr),
    .rd_data_i   (wdata),
    .rs_addr_i   (rs_addr),
    .rs_data_o   (rs_data),
    .rs_busy_o   (rs_busy),
    .iss_valid_i (iss),
    .iss_addr_i  (iss_addr),
    .clr_req_i   (clr_req),
    .ready_o     (ready),
    .err_o       (err)
  );

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
    logic [31:0] act;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(int kind, int port);
    case (kind)
      0:       return rs_data[port*DW +: DW];
      1:       return {31'b0, rs_busy[port]};
      2:       return {31'b0, ready};
      3:       return {31'b0, err};
      default: return 32'(clr_len);
    endcase
  endfunction

  task automatic want(string n, int kind, int port, logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = kind; e.port = port;
    e.val = v; e.act = '0; e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    foreach (exp_q[i])
      if (!exp_q[i].done) begin
        exp_q[i].act  = observe(exp_q[i].kind, exp_q[i].port);
        exp_q[i].done = 1'b1;
      end
  endtask

  task automatic set_rs(int k, int a);
    rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    wren = 0; waddr = '0; wdata = '0;
    iss = 0; iss_addr = '0; clr_req = 0;
  endtask

  task automatic wr(int a, logic [31:0] d);
    wren = 1; waddr = AW'(a); wdata = d;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk); rst = 0; set_rs(0, 5); set_rs(1, 0); #1;
    want("rst_ready", 2, 0, 1);
    want("rst_err", 3, 0, 0);
    want("rst_busy0", 1, 0, 0);
    want("rst_data0", 0, 0, 0);
    want("rst_busy1", 1, 1, 0);
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_write();
    exp_t e;
    @(negedge clk); wr(5, 32'hDEADBEEF); set_rs(0, 5); #1;
    want("wr5_same", 0, 0, BYP ? 32'hDEADBEEF : 32'h0); sample();
    @(negedge clk); idle(); #1;
    want("wr5_next", 0, 0, 32'hDEADBEEF); sample();
    @(negedge clk); wr(0, 32'h1234); set_rs(0, 0); #1;
    want("wr0_same", 0, 0, 0); want("wr0_busy", 1, 0, 0); sample();
    @(negedge clk); idle(); #1;
    want("wr0_next", 0, 0, 0); sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_busy();
    exp_t e;
    @(negedge clk); iss = 1; iss_addr = 7; set_rs(0, 7); #1;
    want("iss7_same", 1, 0, 0); sample();
    @(negedge clk); idle(); #1;
    want("iss7_busy", 1, 0, 1); want("iss7_data", 0, 0, 0); sample();
    @(negedge clk); wr(7, 32'h55); #1;
    want("wb7_busy", 1, 0, BYP ? 0 : 1);
    want("wb7_data", 0, 0, BYP ? 32'h55 : 32'h0); sample();
    @(negedge clk); idle(); #1;
    want("wb7_busy_nx", 1, 0, 0); want("wb7_data_nx", 0, 0, 32'h55);
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    @(negedge clk); iss = 1; iss_addr = 3; set_rs(0, 3);
    @(negedge clk); wr(3, 32'hA); #1;
    want("sc_busy_same", 1, 0, BYP ? 0 : 1); want("sc_err0", 3, 0, 0);
    sample();
    @(negedge clk); idle(); #1;
    want("sc_busy", 1, 0, 1); want("sc_data", 0, 0, 32'hA);
    want("sc_err1", 3, 0, 0); sample();
    @(negedge clk); iss = 1; iss_addr = 3; #1;
    want("dbl_err_pre", 3, 0, 0); sample();
    @(negedge clk); idle(); #1;
    want("dbl_err", 3, 0, 1); want("dbl_busy", 1, 0, 1); sample();
    @(negedge clk); wr(3, 32'hB);
    @(negedge clk); idle(); #1;
    want("err_sticky", 3, 0, 1); want("x3_busy", 1, 0, 0);
    want("x3_data", 0, 0, 32'hB); sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); idle(); wr(i, 32'h1000_0000 | 32'(i));
      if (i == 20) begin iss = 1; iss_addr = 12; end
    end
    @(negedge clk); idle(); set_rs(0, 31); set_rs(1, 12); #1;
    want("fill31", 0, 0, 32'h1000_001F); want("busy12", 1, 1, 1);
    sample();
    @(negedge clk); clr_req = 1; #1;
    want("clr_ready_pre", 2, 0, 1); sample();
    @(negedge clk); idle(); set_rs(0, 9); set_rs(1, 31); #1;
    want("clr_ready0", 2, 0, 0);
    want("clr_rd31", 0, 1, 32'h1000_001F);
    want("clr_rd9", 0, 0, 32'h1000_0009); sample();
    clr_len = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); idle();
      if (c == 5) clr_req = 1;
      if (c == 15) begin
        wr(9, 32'hBAD); iss = 1; iss_addr = 20;
      end
      #1;
      if (ready) break;
      clr_len++;
    end
    @(negedge clk); idle(); #1;
    want("clr_len", 4, 0, 31); want("clr_done_ready", 2, 0, 1);
    sample();
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) set_rs(k, g*4 + k);
      #1;
      for (int k = 0; k < NR; k++) begin
        want($sformatf("clr_x%0d_data", g*4+k), 0, k, 0);
        want($sformatf("clr_x%0d_busy", g*4+k), 1, k, 0);
      end
      sample();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk); idle(); wr(20, 32'h2020_2020);
    @(negedge clk); idle(); wr(31, 32'h3131_3131);
    @(negedge clk); idle(); iss = 1; iss_addr = 5;
    @(negedge clk); idle(); clr_req = 1;
    @(negedge clk); idle();
    set_rs(0, 31); set_rs(1, 20); set_rs(2, 5);
    repeat (9) @(negedge clk);
    #1;
    want("mid_ready", 2, 0, 0); want("mid_x31", 0, 0, 32'h3131_3131);
    want("mid_err", 3, 0, 1); sample();
    #2; rst = 1; #1;
    want("ar_ready", 2, 0, 1); want("ar_err", 3, 0, 0);
    want("ar_x31", 0, 0, 0); want("ar_x20", 0, 1, 0);
    want("ar_busy5", 1, 2, 0); sample();
    @(negedge clk); rst = 0; #1;
    want("ar_rel_ready", 2, 0, 1); sample();
    @(negedge clk); #1;
    want("ar_hold_ready", 2, 0, 1); want("ar_hold_x31", 0, 0, 0);
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  task automatic test_multi_read();
    exp_t e;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle(); wr(i, 32'h0101_0101 * 32'(i));
    end
    @(negedge clk); idle();
    for (int k = 0; k < NR; k++) set_rs(k, k + 1);
    #1;
    for (int k = 0; k < NR; k++) begin
      want($sformatf("mr_p%0d", k), 0, k, 32'h0101_0101 * 32'(k + 1));
      want($sformatf("mr_b%0d", k), 1, k, 0);
    end
    sample();
    @(negedge clk); wr(6, 32'hCAFE_F00D);
    for (int k = 0; k < NR; k++) set_rs(k, 6);
    #1;
    for (int k = 0; k < NR; k++)
      want($sformatf("byp_p%0d", k), 0, k, BYP ? 32'hCAFE_F00D : 32'h0);
    sample();
    @(negedge clk); idle(); #1;
    for (int k = 0; k < NR; k++)
      want($sformatf("wb6_p%0d", k), 0, k, 32'hCAFE_F00D);
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (e.act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, e.act, e.val);
      end
    end
  endtask

  initial begin
    rst = 1; rs_addr = '0; clr_len = 0; idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_write();
    test_busy();
    test_same_cycle();
    test_clear();
    test_async_reset();
    test_multi_read();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
